// File: rtl/inst_mem_responder.sv
// -----------------------------------------------------------------------------
// inst_mem_responder
//
// Instruction fetch responder backed by a loadable word-addressed memory.
// Accepted fetch requests flow through two pipeline registers (S1 holds the
// address, S2 reads memory and classifies the request) into a 2-entry output
// FIFO. Responses come back in acceptance order with a minimum latency of two
// cycles from the accepting edge. Misaligned or out-of-range fetches return a
// NOP (addi x0, x0, 0) with resp_err set.
//
// Ports
//   clk         single clock, all state on its rising edge
//   reset       synchronous, active-high reset (memory contents are kept)
//   req_valid   fetch request present
//   req_ready   request accepted this cycle when req_valid is also high
//   req_addr    64-bit byte address (program counter)
//   resp_valid  response present at the head of the output FIFO
//   resp_ready  consumer takes the response this cycle
//   resp_inst   fetched instruction word (NOP on error)
//   resp_addr   req_addr of the request being answered
//   resp_err    request was misaligned or beyond the memory
//   wr_en       memory load strobe (also honoured during reset)
//   wr_addr     word index to load
//   wr_data     word to load
// -----------------------------------------------------------------------------
module inst_mem_responder #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned MAXOUT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [63:0]              req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_inst,
    output logic [63:0]              resp_addr,
    output logic                     resp_err,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [31:0]              wr_data
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(MAXOUT + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [63:0] LIMIT = 64'(DEPTH) << 2;

    typedef struct packed {
        logic        err;
        logic [63:0] addr;
        logic [31:0] inst;
    } entry_t;

    // ------------------------------------------------------------------
    // Instruction memory: no reset, combinational read from S2
    // ------------------------------------------------------------------
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic          s1_valid_q, s1_valid_d;
    logic [63:0]   s1_addr_q, s1_addr_d;
    logic          s2_valid_q, s2_valid_d;
    logic [63:0]   s2_addr_q, s2_addr_d;
    entry_t [1:0]  fifo_q, fifo_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    fifo_cnt_q, fifo_cnt_d;

    // ------------------------------------------------------------------
    // Handshakes and pipeline flow control
    // ------------------------------------------------------------------
    logic          accept;
    logic          pop;
    logic          push;
    logic          fifo_full;
    logic          s1_move;
    logic [AW-1:0] s2_idx;
    logic [31:0]   s2_rdata;
    entry_t        s2_entry;

    // A response handshake in the same cycle deliberately does not free a slot.
    assign req_ready  = !reset && (out_cnt_q < CW'(MAXOUT));
    assign accept     = req_valid && req_ready;
    assign resp_valid = (fifo_cnt_q != 2'd0);
    assign pop        = resp_valid && resp_ready;
    assign fifo_full  = (fifo_cnt_q == 2'd2);

    // S2 normally drains every cycle. Only when the FIFO is full and not being
    // popped does S2 hold; S1 then holds behind it. With MAXOUT <= 4 the
    // outstanding limit guarantees S1 is free whenever a request is accepted.
    assign push    = s2_valid_q && (!fifo_full || pop);
    assign s1_move = s1_valid_q && (!s2_valid_q || push);

    // Memory read with write-first forwarding for a same-edge load.
    assign s2_idx   = s2_addr_q[AW+1:2];
    assign s2_rdata = (wr_en && (wr_addr == s2_idx)) ? wr_data : mem[s2_idx];

    always_comb begin
        s2_entry      = '0;
        s2_entry.addr = s2_addr_q;
        s2_entry.err  = (s2_addr_q[1:0] != 2'b00) || (s2_addr_q >= LIMIT);
        s2_entry.inst = s2_entry.err ? NOP : s2_rdata;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        out_cnt_d = out_cnt_q;
        if (accept && !pop) begin
            out_cnt_d = out_cnt_q + CW'(1);
        end else if (!accept && pop) begin
            out_cnt_d = out_cnt_q - CW'(1);
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_addr_d  = s1_addr_q;
        s2_valid_d = s2_valid_q;
        s2_addr_d  = s2_addr_q;

        if (push) begin
            s2_valid_d = 1'b0;
        end
        if (s1_move) begin
            s2_valid_d = 1'b1;
            s2_addr_d  = s1_addr_q;
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_addr_d  = req_addr;
        end
    end

    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;

        if (push) begin
            fifo_d[wr_ptr_q] = s2_entry;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 2'd1;
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            fifo_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            out_cnt_q  <= out_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            s2_valid_q <= s2_valid_d;
            s2_addr_q  <= s2_addr_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Outputs come straight from the FIFO head; storage is cleared by reset,
    // so they read zero after reset.
    assign resp_inst = fifo_q[rd_ptr_q].inst;
    assign resp_addr = fifo_q[rd_ptr_q].addr;
    assign resp_err  = fifo_q[rd_ptr_q].err;

endmodule

// File: tb/tb_inst_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_inst_mem_responder
//
// Scoreboard bench: the driver pushes the expected response for every accepted
// request (computed from a plain array model of memory); an independent monitor
// pops and compares on every response handshake and checks output stability
// while the consumer stalls.
// -----------------------------------------------------------------------------
module tb_inst_mem_responder;

    localparam int unsigned DEPTH  = 256;
    localparam int unsigned MAXOUT = 4;

    logic                     clk;
    logic                     reset;
    logic                     req_valid;
    logic                     req_ready;
    logic [63:0]              req_addr;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [31:0]              resp_inst;
    logic [63:0]              resp_addr;
    logic                     resp_err;
    logic                     wr_en;
    logic [$clog2(DEPTH)-1:0] wr_addr;
    logic [31:0]              wr_data;

    inst_mem_responder #(
        .DEPTH  (DEPTH),
        .MAXOUT (MAXOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_inst  (resp_inst),
        .resp_addr  (resp_addr),
        .resp_err   (resp_err),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] addr;
        logic        err;
        int          acc_cyc;
        bit          exact;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [DEPTH];
    int          vectors     = 0;
    int          miscompares = 0;
    int          n_acc       = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a fetch is an error if misaligned or past the memory end.
    function automatic exp_t model(input logic [63:0] a);
        exp_t e;
        e.addr    = a;
        e.err     = (a % 64'd4 != 64'd0) || (a >= 64'(DEPTH) * 64'd4);
        e.inst    = e.err ? 32'h0000_0013 : model_mem[int'((a / 64'd4) % 64'(DEPTH))];
        e.acc_cyc = 0;
        e.exact   = 1'b0;
        return e;
    endfunction

    // One clock cycle of stimulus; inputs change 1 time unit after posedge.
    task automatic cycle(input bit rv, input logic [63:0] ra, input bit rr,
                         input bit we, input int wa, input logic [31:0] wd, input bit exact);
        exp_t e;
        req_valid  = rv;
        req_addr   = ra;
        resp_ready = rr;
        wr_en      = we;
        wr_addr    = wa[$clog2(DEPTH)-1:0];
        wr_data    = wd;
        @(negedge clk);
        if (we) model_mem[wa] = wd;
        if (rv && req_ready) begin
            e         = model(ra);
            e.acc_cyc = cyc;
            e.exact   = exact;
            sb.push_back(e);
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [63:0] a, input bit rr);
        cycle(1'b1, a, rr, 1'b0, 0, 32'h0, 1'b0);
    endtask

    task automatic idle(input bit rr);
        cycle(1'b0, 64'h0, rr, 1'b0, 0, 32'h0, 1'b0);
    endtask

    task automatic wr(input int wa, input logic [31:0] wd);
        cycle(1'b0, 64'h0, 1'b1, 1'b1, wa, wd, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            idle(1'b1);
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        idle(1'b1);
        idle(1'b1);
        @(negedge clk);
        chk("drain_resp_valid", 64'(resp_valid), 64'd0);
        chk("drain_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Hold reset for n edges, optionally loading one word meanwhile.
    task automatic do_reset(input int n, input bit we, input int wa, input logic [31:0] wd);
        reset      = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        wr_en      = we;
        wr_addr    = wa[$clog2(DEPTH)-1:0];
        wr_data    = wd;
        sb.delete();
        if (we) model_mem[wa] = wd;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        repeat (n) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("rst_resp_inst", 64'(resp_inst), 64'd0);
            chk("rst_resp_addr", resp_addr, 64'd0);
            chk("rst_resp_err", 64'(resp_err), 64'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each handshaken response against the scoreboard head.
    initial begin
        exp_t        e;
        bit          stall;
        logic [31:0] h_inst;
        logic [63:0] h_addr;
        logic        h_err;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_valid", 64'(resp_valid), 64'd1);
                    chk("hold_inst", 64'(resp_inst), 64'(h_inst));
                    chk("hold_addr", resp_addr, h_addr);
                    chk("hold_err", 64'(resp_err), 64'(h_err));
                end
                if (resp_valid && resp_ready) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_resp: got addr %h, want no response", resp_addr);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_addr", resp_addr, e.addr);
                        chk("resp_inst", 64'(resp_inst), 64'(e.inst));
                        chk("resp_err", 64'(resp_err), 64'(e.err));
                        if (e.exact) chk("first_latency", 64'(cyc), 64'(e.acc_cyc + 3));
                        else chk("latency_min", 64'(cyc >= e.acc_cyc + 3), 64'd1);
                    end
                end
                stall  = resp_valid && !resp_ready;
                h_inst = resp_inst;
                h_addr = resp_addr;
                h_err  = resp_err;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        exp_t        e;
        int          n0;
        int          kind;
        logic [63:0] a;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;

        // Reset, with a load during reset that must stick.
        do_reset(3, 1'b1, 10, 32'hCAFE_0010);

        // Load a few words (A0..A3 first), including the last word.
        wr(0, 32'hA0A0_0000);
        wr(1, 32'hA1A1_1111);
        wr(2, 32'hA2A2_2222);
        wr(3, 32'hA3A3_3333);
        for (int i = 4; i < 16; i++) if (i != 10) wr(i, 32'h1111_0000 + 32'(i));
        wr(DEPTH - 1, 32'hF00D_00FF);
        idle(1'b1);

        // Back-to-back aligned fetches, first one with exact latency check.
        cycle(1'b1, 64'h0, 1'b1, 1'b0, 0, 32'h0, 1'b1);
        req(64'h4, 1'b1);
        req(64'h8, 1'b1);
        req(64'hC, 1'b1);
        drain();

        // Error cases and boundaries.
        req(64'h6, 1'b1);
        req(64'h400, 1'b1);
        req(64'h3FC, 1'b1);
        req(64'h3FD, 1'b1);
        req(64'h8000_0000_0000_0000, 1'b1);
        req(64'h28, 1'b1);
        drain();

        // Write-first: load word 5 on the edge the 0x14 fetch reads it.
        req(64'h14, 1'b1);
        e = sb.pop_back();
        e.inst = 32'hDEAD_BEEF;
        sb.push_back(e);
        idle(1'b1);
        wr(5, 32'hDEAD_BEEF);
        drain();
        req(64'h14, 1'b1);
        drain();

        // Consumer stalled: exactly MAXOUT accepts, then release.
        n0 = n_acc;
        for (int i = 0; i < 8; i++) req(64'(i * 4), 1'b0);
        chk("stall_accepts", 64'(n_acc - n0), 64'(MAXOUT));
        req_valid = 1'b0;
        @(negedge clk);
        chk("stall_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        drain();

        // Reset with 3 outstanding; nothing stale may appear afterwards.
        req(64'h0, 1'b0);
        req(64'h4, 1'b0);
        req(64'h8, 1'b0);
        idle(1'b0);
        do_reset(1, 1'b0, 0, 32'h0);
        for (int i = 0; i < 6; i++) idle(1'b1);
        req(64'h0, 1'b1);
        req(64'h4, 1'b1);
        req(64'h28, 1'b1);
        req(64'h3C, 1'b1);
        drain();

        // Fill the whole memory with random words.
        for (int i = 0; i < int'(DEPTH); i++) wr(i, $urandom);
        idle(1'b1);

        // Throughput: one accept per cycle with the consumer always ready.
        n0 = n_acc;
        for (int i = 0; i < 20; i++) req(64'(64 + 4 * i), 1'b1);
        chk("b2b_accepts", 64'(n_acc - n0), 64'd20);
        drain();

        // Randomised traffic with random backpressure and one reset mid-stream.
        for (int i = 0; i < 1500; i++) begin
            kind = int'($urandom_range(0, 19));
            if (kind == 0) a = {$urandom, $urandom};
            else if (kind == 1) a = 64'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else if (kind == 2) a = 64'(DEPTH * 4 + 4 * $urandom_range(0, 15));
            else a = 64'($urandom_range(0, DEPTH - 1) * 4);
            if (i == 700) do_reset(2, 1'b0, 0, 32'h0);
            cycle(($urandom_range(0, 9) < 7), a, ($urandom_range(0, 9) < 7),
                  1'b0, 0, 32'h0, 1'b0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
